// File: rtl/tech_sync_filter_if.sv
// Channel bundle for tech_sync_filter: raw pad inputs and bypass in,
// synchronized level, filtered level and edge pulses out.
interface tech_sync_filter_if #(
    parameter int WIDTH = 1
);
    logic             filter_bypass_i;
    logic [WIDTH-1:0] signal_i;
    logic [WIDTH-1:0] signal_sync_o;
    logic [WIDTH-1:0] signal_filt_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;

    modport master (
        output filter_bypass_i,
        output signal_i,
        input  signal_sync_o,
        input  signal_filt_o,
        input  rise_o,
        input  fall_o
    );

    modport slave (
        input  filter_bypass_i,
        input  signal_i,
        output signal_sync_o,
        output signal_filt_o,
        output rise_o,
        output fall_o
    );
endinterface

// File: rtl/tech_sync_filter.sv
// Multi-channel pad conditioner: per-bit synchronizer chain, then a
// consecutive-mismatch glitch filter with registered rise/fall pulses.
module tech_sync_filter #(
    parameter int               WIDTH      = 1,
    parameter int               SYNC_DEPTH = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    tech_sync_filter_if.slave sf_if
);

    localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    generate
        if (SYNC_DEPTH < 2) begin : g_bad_depth
            $error("tech_sync_filter: SYNC_DEPTH must be >= 2");
        end
        if (FILTER_LEN < 1) begin : g_bad_len
            $error("tech_sync_filter: FILTER_LEN must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] sync_q [SYNC_DEPTH];
    logic [WIDTH-1:0] sync_last;

    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_DEPTH; s++) begin
                sync_q[s] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= sf_if.signal_i;
            for (int s = 1; s < SYNC_DEPTH; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_DEPTH-1];

    // A channel only adopts the synced level after FILTER_LEN consecutive
    // mismatching edges; any agreement (or bypass) drops the count to zero.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sf_if.filter_bypass_i) begin
                filt_d[i] = sync_last[i];
            end else if (sync_last[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync_last[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d = ~filt_q & filt_d;
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= RESET_VAL;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sf_if.signal_sync_o = sync_last;
    assign sf_if.signal_filt_o = filt_q;
    assign sf_if.rise_o        = rise_q;
    assign sf_if.fall_o        = fall_q;

endmodule

// File: tb/tb_tech_sync_filter.sv
// Bench for tech_sync_filter: three configurations checked against a
// run-length reference model, a vector table and directed corner sequences.
module tb_tech_sync_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tech_sync_filter_if #(.WIDTH(4)) if_a ();
    tech_sync_filter_if #(.WIDTH(4)) if_b ();
    tech_sync_filter_if #(.WIDTH(2)) if_c ();

    tech_sync_filter #(.WIDTH(4), .SYNC_DEPTH(2), .FILTER_LEN(4), .RESET_VAL(4'b0000))
        dut_a (.clk(clk), .rst(rst), .sf_if(if_a));
    tech_sync_filter #(.WIDTH(4), .SYNC_DEPTH(3), .FILTER_LEN(4), .RESET_VAL(4'b1010))
        dut_b (.clk(clk), .rst(rst), .sf_if(if_b));
    tech_sync_filter #(.WIDTH(2), .SYNC_DEPTH(2), .FILTER_LEN(1), .RESET_VAL(2'b00))
        dut_c (.clk(clk), .rst(rst), .sf_if(if_c));

    int total = 0;
    int bad   = 0;

    // Per-configuration constants for the reference model.
    int         P_D [3] = '{2, 3, 2};
    int         P_F [3] = '{4, 4, 1};
    logic [3:0] P_M [3] = '{4'b1111, 4'b1111, 4'b0011};
    logic [3:0] P_R [3] = '{4'b0000, 4'b1010, 4'b0000};

    // Model state: input delay line, filtered level, pulses, mismatch run length.
    logic [3:0] m_pipe [3][3];
    logic [3:0] m_filt [3];
    logic [3:0] m_rise [3];
    logic [3:0] m_fall [3];
    int         m_run  [3][4];

    task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model_reset(int k);
        for (int s = 0; s < 3; s++) m_pipe[k][s] = P_R[k];
        m_filt[k] = P_R[k];
        m_rise[k] = '0;
        m_fall[k] = '0;
        for (int c = 0; c < 4; c++) m_run[k][c] = 0;
    endfunction

    // One clock edge: the filter looks at what the synchronizer showed before
    // the edge; a level is accepted once it has disagreed F edges in a row.
    function automatic void model_edge(int k, logic [3:0] sig, logic byp);
        logic [3:0] seen;
        logic [3:0] nf;
        seen = m_pipe[k][P_D[k]-1];
        nf   = m_filt[k];
        for (int c = 0; c < 4; c++) begin
            if (P_M[k][c]) begin
                if (byp) begin
                    nf[c] = seen[c];
                    m_run[k][c] = 0;
                end else if (seen[c] != m_filt[k][c]) begin
                    m_run[k][c] = m_run[k][c] + 1;
                    if (m_run[k][c] >= P_F[k]) begin
                        nf[c] = seen[c];
                        m_run[k][c] = 0;
                    end
                end else begin
                    m_run[k][c] = 0;
                end
            end
        end
        m_rise[k] = nf & ~m_filt[k];
        m_fall[k] = m_filt[k] & ~nf;
        m_filt[k] = nf;
        for (int s = P_D[k] - 1; s > 0; s--) m_pipe[k][s] = m_pipe[k][s-1];
        m_pipe[k][0] = sig & P_M[k];
    endfunction

    function automatic logic [3:0] in_sig(int k);
        case (k)
            0:       return if_a.signal_i;
            1:       return if_b.signal_i;
            default: return {2'b00, if_c.signal_i};
        endcase
    endfunction

    function automatic logic in_byp(int k);
        case (k)
            0:       return if_a.filter_bypass_i;
            1:       return if_b.filter_bypass_i;
            default: return if_c.filter_bypass_i;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) model_reset(k);
            else     model_edge(k, in_sig(k), in_byp(k));
        end
        @(negedge clk);
    endtask

    task automatic cmp_model(int k, string tag);
        logic [3:0] s, f, r, fl;
        case (k)
            0: begin s = if_a.signal_sync_o; f = if_a.signal_filt_o; r = if_a.rise_o; fl = if_a.fall_o; end
            1: begin s = if_b.signal_sync_o; f = if_b.signal_filt_o; r = if_b.rise_o; fl = if_b.fall_o; end
            default: begin
                s  = {2'b00, if_c.signal_sync_o};
                f  = {2'b00, if_c.signal_filt_o};
                r  = {2'b00, if_c.rise_o};
                fl = {2'b00, if_c.fall_o};
            end
        endcase
        chk($sformatf("%s dut%0d sync", tag, k), s,  m_pipe[k][P_D[k]-1]);
        chk($sformatf("%s dut%0d filt", tag, k), f,  m_filt[k]);
        chk($sformatf("%s dut%0d rise", tag, k), r,  m_rise[k]);
        chk($sformatf("%s dut%0d fall", tag, k), fl, m_fall[k]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) model_reset(k);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       byp;
        logic [3:0] sig;
        logic [3:0] e_sync;
        logic [3:0] e_filt;
        logic [3:0] e_rise;
        logic [3:0] e_fall;
    } vec_t;

    vec_t vt[$];

    function automatic void add(logic byp, logic [3:0] sig, logic [3:0] es,
                                logic [3:0] ef, logic [3:0] er, logic [3:0] efl);
        vec_t v;
        v.byp = byp; v.sig = sig; v.e_sync = es; v.e_filt = ef; v.e_rise = er; v.e_fall = efl;
        vt.push_back(v);
    endfunction

    initial begin
        int first_edge;
        int pulses;
        logic [3:0] nb;

        if_a.filter_bypass_i = 1'b0; if_a.signal_i = 4'b0000;
        if_b.filter_bypass_i = 1'b0; if_b.signal_i = 4'b1010;
        if_c.filter_bypass_i = 1'b0; if_c.signal_i = 2'b00;
        @(negedge clk);
        do_reset();

        chk("reset a filt", if_a.signal_filt_o, 4'b0000);
        chk("reset b sync", if_b.signal_sync_o, 4'b1010);
        chk("reset b filt", if_b.signal_filt_o, 4'b1010);
        chk("reset b pulses", if_b.rise_o | if_b.fall_o, 4'b0000);
        for (int k = 0; k < 3; k++) cmp_model(k, "reset");

        // D=2, F=4 on channel 0: 3-cycle glitch, step up, step down,
        // then a bypass edge mid-count followed by a fresh mismatch run.
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0);
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
        add(0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        foreach (vt[i]) begin
            if_a.filter_bypass_i = vt[i].byp;
            if_a.signal_i        = vt[i].sig;
            cyc();
            chk($sformatf("tbl[%0d] sync", i), if_a.signal_sync_o, vt[i].e_sync);
            chk($sformatf("tbl[%0d] filt", i), if_a.signal_filt_o, vt[i].e_filt);
            chk($sformatf("tbl[%0d] rise", i), if_a.rise_o, vt[i].e_rise);
            chk($sformatf("tbl[%0d] fall", i), if_a.fall_o, vt[i].e_fall);
        end

        // Reset asserted while channel 0 of dut_b has counted two mismatches.
        if_b.signal_i = 4'b1011;
        repeat (5) cyc();
        chk("midcount b filt", if_b.signal_filt_o, 4'b1010);
        chk("midcount b sync", if_b.signal_sync_o, 4'b1011);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) model_reset(k);
        #1;
        chk("async rst b sync", if_b.signal_sync_o, 4'b1010);
        chk("async rst b filt", if_b.signal_filt_o, 4'b1010);
        chk("async rst b rise", if_b.rise_o, 4'b0000);
        chk("async rst b fall", if_b.fall_o, 4'b0000);
        if_b.signal_i = 4'b1010;
        cyc();
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            cyc();
            chk($sformatf("post rst b pulses %0d", n), if_b.rise_o | if_b.fall_o, 4'b0000);
            chk($sformatf("post rst b filt %0d", n), if_b.signal_filt_o, 4'b1010);
        end

        // Bypass with D=3: toggle channel 0 every 2 cycles.
        if_b.filter_bypass_i = 1'b1;
        cyc();
        first_edge = -1;
        pulses = 0;
        for (int n = 0; n < 22; n++) begin
            if (n < 16 && n % 2 == 0) if_b.signal_i[0] = ~if_b.signal_i[0];
            cyc();
            cmp_model(1, "bypass");
            if (first_edge < 0 && if_b.signal_filt_o[0]) first_edge = n + 1;
            pulses += int'(if_b.rise_o[0]) + int'(if_b.fall_o[0]);
        end
        chk_int("bypass latency", first_edge, 4);
        chk_int("bypass pulse count", pulses, 8);
        if_b.filter_bypass_i = 1'b0;

        // F=1: opposite transitions on two channels in the same cycle.
        if_c.signal_i = 2'b10;
        repeat (4) begin cyc(); cmp_model(2, "f1 setup"); end
        chk("f1 setup filt", {2'b00, if_c.signal_filt_o}, 4'b0010);
        if_c.signal_i = 2'b01;
        repeat (3) cyc();
        chk("f1 rise", {2'b00, if_c.rise_o}, 4'b0001);
        chk("f1 fall", {2'b00, if_c.fall_o}, 4'b0010);
        chk("f1 filt", {2'b00, if_c.signal_filt_o}, 4'b0001);
        cyc();
        chk("f1 pulses clear", {2'b00, if_c.rise_o | if_c.fall_o}, 4'b0000);

        // Randomized run on all three configurations against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 3; k++) begin
                nb = '0;
                for (int c = 0; c < 4; c++) nb[c] = ($urandom_range(0, 5) == 0);
                nb &= P_M[k];
                case (k)
                    0: begin
                        if_a.signal_i ^= nb;
                        if ($urandom_range(0, 39) == 0) if_a.filter_bypass_i = ~if_a.filter_bypass_i;
                    end
                    1: begin
                        if_b.signal_i ^= nb;
                        if ($urandom_range(0, 39) == 0) if_b.filter_bypass_i = ~if_b.filter_bypass_i;
                    end
                    default: begin
                        if_c.signal_i ^= nb[1:0];
                        if ($urandom_range(0, 39) == 0) if_c.filter_bypass_i = ~if_c.filter_bypass_i;
                    end
                endcase
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc();
            for (int k = 0; k < 3; k++) cmp_model(k, "rand");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
